// File: rtl/snn_mem_pkg.sv
// Shared types and helpers for the synaptic weight memory scheduler.
// No logic of its own; pure declarations.
// Not applicable (no datapath).
package snn_mem_pkg;

    // Requester index field is sized for the largest supported requester count (16).
    localparam int TAG_IDX_W = 4;

    // Response status codes carried in the tag's err field.
    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // Per-operation tag travelling alongside the memory command through both stages.
    typedef struct packed {
        logic                 is_host;
        logic [TAG_IDX_W-1:0] req_idx;
        logic                 err;
    } tag_t;

    // Minimum address width able to index a memory of the given depth.
    function automatic int addr_w_for(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/synapse_mem_scheduler_rr_arbiter.sv
// Round-robin one-hot picker over a request vector, starting the search at a registered pointer.
// Pick is combinational (0 cycles); pointer moves to winner+1 on the clock edge of an accept.
// No backpressure of its own: an un-accepted pick leaves the pointer unchanged.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan N positions from the pointer, wrapping, and take the first active request.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        int            pos;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        pos     = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr_q) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IW'(pos);
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end

    // Next pointer is the slot after the winner, wrapping at N.
    always_comb begin
        ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Pointer advances only when the pick was actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/synapse_mem_scheduler.sv
// Shares one single-port weight memory between NUM_REQ spike fetchers and a host port.
// Grant in N, memory command registered in N+1, response pulse in N+2; one grant per cycle.
// Ready is combinational from valids and state; responses have no backpressure.
module synapse_mem_scheduler
    import snn_mem_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int NUM_SYNAPSES   = 72929,
    parameter int ADDR_W         = addr_w_for(NUM_SYNAPSES),
    parameter int WEIGHT_W       = 16,
    parameter int HOST_BURST_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sched_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [WEIGHT_W-1:0]       rsp_weight,
    output logic                      rsp_err,
    input  logic                      host_valid,
    input  logic                      host_we,
    input  logic [ADDR_W-1:0]         host_addr,
    input  logic [WEIGHT_W-1:0]       host_wdata,
    output logic                      host_ready,
    output logic                      host_rvalid,
    output logic [WEIGHT_W-1:0]       host_rdata,
    output logic                      host_err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WEIGHT_W-1:0]       mem_wdata,
    input  logic [WEIGHT_W-1:0]       mem_rdata,
    output logic                      busy
);

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STREAK_W = $clog2(HOST_BURST_MAX + 1);
    localparam logic [ADDR_W:0]     ADDR_LIMIT = (ADDR_W + 1)'(NUM_SYNAPSES);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(HOST_BURST_MAX);

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                any_req;
    logic                host_win;
    logic                req_win;
    logic                grant;
    logic [ADDR_W-1:0]   g_addr;
    logic                oor;
    tag_t                tag_d;

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                s1_vld_q, s2_vld_q;
    tag_t                s1_tag_q, s2_tag_q;
    logic                s1_we_q, s2_we_q;
    logic                mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [WEIGHT_W-1:0] mem_wdata_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .accept  (req_win),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Host-vs-requester selection: host wins until its streak saturates while spikes wait.
    always_comb begin
        any_req    = |req_valid;
        host_win   = sched_en && !rst && host_valid && ((streak_q < STREAK_MAX) || !any_req);
        req_win    = sched_en && !rst && !host_win && any_req;
        grant      = host_win || req_win;
        host_ready = host_win;
        req_ready  = req_win ? arb_gnt : '0;
    end

    // Granted address, range check and the tag that follows the operation.
    always_comb begin
        g_addr        = host_win ? host_addr : req_addr[arb_idx*ADDR_W +: ADDR_W];
        oor           = ({1'b0, g_addr} >= ADDR_LIMIT);
        tag_d.is_host = host_win;
        tag_d.req_idx = host_win ? '0 : TAG_IDX_W'(arb_idx);
        tag_d.err     = oor ? RSP_ERR : RSP_OK;
    end

    // Fairness streak: counts host grants only while spikes are waiting, saturating.
    always_comb begin
        streak_d = streak_q;
        if (!any_req || req_win) begin
            streak_d = '0;
        end else if (host_win && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Streak register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Stage 1: registered memory command; out-of-range grants keep mem_en low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_tag_q    <= '0;
            s1_we_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            s1_vld_q <= grant;
            if (grant) begin
                s1_tag_q    <= tag_d;
                s1_we_q     <= host_win && host_we;
                mem_en_q    <= !oor;
                mem_we_q    <= host_win && host_we && !oor;
                mem_addr_q  <= g_addr;
                mem_wdata_q <= host_win ? host_wdata : '0;
            end else begin
                mem_en_q    <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
            end
        end
    end

    // Stage 2: tag only; data comes straight from the memory read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_tag_q <= '0;
            s2_we_q  <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_tag_q <= s1_tag_q;
            s2_we_q  <= s1_we_q;
        end
    end

    // Response steering: one pulse to the owner, data zeroed on errors and host writes.
    always_comb begin
        rsp_valid   = '0;
        rsp_weight  = '0;
        rsp_err     = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        host_err    = 1'b0;
        if (s2_vld_q) begin
            if (s2_tag_q.is_host) begin
                host_rvalid = 1'b1;
                host_err    = (s2_tag_q.err == RSP_ERR);
                if (!host_err && !s2_we_q) begin
                    host_rdata = mem_rdata;
                end
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid[i] = (s2_tag_q.req_idx == TAG_IDX_W'(i));
                end
                rsp_err = (s2_tag_q.err == RSP_ERR);
                if (!rsp_err) begin
                    rsp_weight = mem_rdata;
                end
            end
        end
    end

    // Memory command and occupancy outputs.
    always_comb begin
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        busy      = s1_vld_q || s2_vld_q;
    end

endmodule
